mem_stage: RTL

- Pipeline stage downstream of execute: consumes the registered opcode_o/alu_result_o pair plus store data and destination register.
- Loads and stores are resolved against a data-memory port with a req/gnt/rvalid handshake. Non-memory results pass through.
- Presents a one-cycle-valid writeback bundle to the register file.
- Stalls upstream via ready_o while a memory transaction is outstanding.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/mem_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, memory-stage FSM states and
// small opcode classification helpers used by execute and mem_stage.
package cpu_pkg;

  typedef enum logic [4:0] {
    OP_ADDI  = 5'b00000,
    OP_LOAD  = 5'b01000,
    OP_STORE = 5'b01001
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // True for opcodes that go out on the data-memory port.
  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // True for opcodes that produce a register-file result (stores do not).
  function automatic logic writes_rd(input logic [4:0] op);
    return (op != OP_STORE);
  endfunction

  // Word accesses only: any nonzero low address bit is a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory pipeline stage. ALU results pass straight through to writeback;
// loads and stores are held in registers while a req/gnt/rvalid handshake
// with data memory completes, and upstream is stalled via ready_o meanwhile.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [4:0]        opcode_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [4:0]        rd_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              valid_o,
  output logic [4:0]        opcode_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [4:0]        rd_o,
  output logic              wb_en_o,
  output logic              misaligned_o
);

  mem_state_e        state_r, state_s;

  // Holding registers for the instruction currently in the stage
  logic [4:0]        hold_op_r;
  logic [ADDR_W-1:0] hold_addr_r;
  logic [DATA_W-1:0] hold_wdata_r;
  logic [4:0]        hold_rd_r;

  // Writeback bundle registers and their next values
  logic              valid_r, valid_s;
  logic [4:0]        opcode_r, opcode_s;
  logic [DATA_W-1:0] wb_data_r, wb_data_s;
  logic [4:0]        rd_r, rd_s;
  logic              wb_en_r, wb_en_s;
  logic              mis_r, mis_s;

  logic              capture_s;
  logic              hold_wb_en_s;

  assign capture_s    = (state_r == IDLE) && valid_i;
  assign hold_wb_en_s = writes_rd(hold_op_r) && (hold_rd_r != 5'd0);

  // Next-state and writeback-bundle decode
  always_comb begin
    state_s   = state_r;
    valid_s   = 1'b0;
    wb_en_s   = 1'b0;
    mis_s     = 1'b0;
    opcode_s  = opcode_r;
    rd_s      = rd_r;
    wb_data_s = wb_data_r;
    case (state_r)
      IDLE: begin
        if (valid_i) begin
          opcode_s  = opcode_i;
          rd_s      = rd_i;
          wb_data_s = alu_result_i;
          if (!is_mem_op(opcode_i)) begin
            valid_s = 1'b1;
            wb_en_s = writes_rd(opcode_i) && (rd_i != 5'd0);
          end else if (is_misaligned(alu_result_i[1:0])) begin
            // Dropped access: report it, never touch memory or the register file
            valid_s = 1'b1;
            mis_s   = 1'b1;
          end else begin
            state_s = REQ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          if (hold_op_r == OP_STORE) begin
            valid_s = 1'b1;
            state_s = IDLE;
          end else if (dmem_rvalid_i) begin
            // Zero-latency memory: data arrives with the grant
            valid_s   = 1'b1;
            wb_data_s = dmem_rdata_i;
            wb_en_s   = hold_wb_en_s;
            state_s   = IDLE;
          end else begin
            state_s = RESP;
          end
        end else begin
          // An rvalid without a grant belongs to no request of ours
          state_s = REQ;
        end
      end
      RESP: begin
        if (dmem_rvalid_i) begin
          valid_s   = 1'b1;
          wb_data_s = dmem_rdata_i;
          wb_en_s   = hold_wb_en_s;
          state_s   = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture the incoming instruction whenever the stage accepts one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_op_r    <= 5'd0;
      hold_addr_r  <= {ADDR_W{1'b0}};
      hold_wdata_r <= {DATA_W{1'b0}};
      hold_rd_r    <= 5'd0;
    end else if (capture_s) begin
      hold_op_r    <= opcode_i;
      hold_addr_r  <= alu_result_i[ADDR_W-1:0];
      hold_wdata_r <= store_data_i;
      hold_rd_r    <= rd_i;
    end
  end

  // Writeback bundle registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r   <= 1'b0;
      opcode_r  <= 5'd0;
      wb_data_r <= {DATA_W{1'b0}};
      rd_r      <= 5'd0;
      wb_en_r   <= 1'b0;
      mis_r     <= 1'b0;
    end else begin
      valid_r   <= valid_s;
      opcode_r  <= opcode_s;
      wb_data_r <= wb_data_s;
      rd_r      <= rd_s;
      wb_en_r   <= wb_en_s;
      mis_r     <= mis_s;
    end
  end

  // Handshake signals come straight off the state register, so an async
  // reset drops dmem_req_o at once; ready_o is also held low during reset.
  assign ready_o      = rst_n && (state_r == IDLE);
  assign dmem_req_o   = (state_r == REQ);
  assign dmem_we_o    = (state_r == REQ) && (hold_op_r == OP_STORE);
  assign dmem_addr_o  = hold_addr_r;
  assign dmem_wdata_o = hold_wdata_r;

  assign valid_o      = valid_r;
  assign opcode_o     = opcode_r;
  assign wb_data_o    = wb_data_r;
  assign rd_o         = rd_r;
  assign wb_en_o      = wb_en_r;
  assign misaligned_o = mis_r;

endmodule
